// File: rtl/spi_receiver_if.sv
// SPI receiver bus interface.
// Groups the serial inputs (sclk, cs, mosi) and the word-level outputs
// (dout, valid, err, busy) of spi_receiver.
//   master : upstream transmitter / observer side (drives sclk, cs, mosi)
//   slave  : receiver side (drives dout, valid, err, busy)
interface spi_receiver_if #(
  parameter int unsigned WIDTH = 12
);
  logic             sclk;
  logic             cs;
  logic             mosi;
  logic [WIDTH-1:0] dout;
  logic             valid;
  logic             err;
  logic             busy;

  modport master (
    output sclk, cs, mosi,
    input  dout, valid, err, busy
  );

  modport slave (
    input  sclk, cs, mosi,
    output dout, valid, err, busy
  );
endinterface

// File: rtl/spi_receiver.sv
// SPI receiver (LSB first, capture on falling sclk), oversampled by clk.
// Ports:
//   clk   : system clock, all state updates on its rising edge
//   rst_n : asynchronous active-low reset
//   bus   : spi_receiver_if.slave
//           sclk/cs/mosi in (asynchronous to clk),
//           dout  : last complete word, held between frames
//           valid : one-clk pulse when dout updates
//           err   : one-clk pulse when a frame is aborted early
//           busy  : high while not idle
module spi_receiver #(
  parameter int unsigned WIDTH      = 12,
  parameter int unsigned SKIP_EDGES = 1
) (
  input logic           clk,
  input logic           rst_n,
  spi_receiver_if.slave bus
);
  localparam int unsigned BcW = $clog2(WIDTH + 1);
  // Skip counter runs 0..SKIP_EDGES-1
  localparam int unsigned SkW = (SKIP_EDGES > 1) ? $clog2(SKIP_EDGES) : 1;
  localparam logic [BcW-1:0] BcLast = BcW'(WIDTH - 1);
  localparam logic [SkW-1:0] SkLast = SkW'(SKIP_EDGES - 1);

  typedef enum logic [1:0] {StIdle, StSkip, StShift, StHold} state_e;

  // Synchronizers plus one extra stage of history for edge detection
  logic [1:0] r_sclk_sync, r_cs_sync, r_mosi_sync;
  logic       r_sclk_prev, r_cs_prev;

  state_e           r_state, w_state_d;
  logic [BcW-1:0]   r_bitcnt, w_bitcnt_d;
  logic [SkW-1:0]   r_skipcnt, w_skipcnt_d;
  logic [WIDTH-1:0] r_shreg, w_shreg_d;
  logic [WIDTH-1:0] r_dout, w_dout_d;
  logic             r_valid, w_valid_d;
  logic             r_err, w_err_d;

  logic w_sclk_fall, w_cs_fall, w_cs_rise, w_mosi;

  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n) begin
      r_sclk_sync <= '0;
      r_cs_sync   <= '0;
      r_mosi_sync <= '0;
      r_sclk_prev <= 1'b0;
      r_cs_prev   <= 1'b0;
    end else begin
      r_sclk_sync <= {r_sclk_sync[0], bus.sclk};
      r_cs_sync   <= {r_cs_sync[0], bus.cs};
      r_mosi_sync <= {r_mosi_sync[0], bus.mosi};
      r_sclk_prev <= r_sclk_sync[1];
      r_cs_prev   <= r_cs_sync[1];
    end
  end

  assign w_sclk_fall = r_sclk_prev & ~r_sclk_sync[1];
  assign w_cs_fall   = r_cs_prev & ~r_cs_sync[1];
  assign w_cs_rise   = ~r_cs_prev & r_cs_sync[1];
  assign w_mosi      = r_mosi_sync[1];

  always_comb begin
    w_state_d   = r_state;
    w_bitcnt_d  = r_bitcnt;
    w_skipcnt_d = r_skipcnt;
    w_shreg_d   = r_shreg;
    w_dout_d    = r_dout;
    w_valid_d   = 1'b0;
    w_err_d     = 1'b0;
    unique case (r_state)
      StIdle: begin
        if (w_cs_fall) begin
          // Clear so an earlier aborted frame cannot leak into this word
          w_shreg_d   = '0;
          w_bitcnt_d  = '0;
          w_skipcnt_d = '0;
          w_state_d   = (SKIP_EDGES == 0) ? StShift : StSkip;
        end
      end
      StSkip: begin
        if (w_cs_rise) begin
          w_err_d   = 1'b1;
          w_state_d = StIdle;
        end else if (w_sclk_fall) begin
          if (r_skipcnt == SkLast) begin
            w_bitcnt_d = '0;
            w_state_d  = StShift;
          end else begin
            w_skipcnt_d = r_skipcnt + 1'b1;
          end
        end
      end
      StShift: begin
        // cs-rise wins over a coincident sclk edge
        if (w_cs_rise) begin
          w_err_d   = 1'b1;
          w_state_d = StIdle;
        end else if (w_sclk_fall) begin
          for (int i = 0; i < WIDTH; i++) begin
            if (r_bitcnt == BcW'(i)) w_shreg_d[i] = w_mosi;
          end
          w_bitcnt_d = r_bitcnt + 1'b1;
          if (r_bitcnt == BcLast) w_state_d = StHold;
        end
      end
      StHold: begin
        if (w_cs_rise) begin
          w_dout_d  = r_shreg;
          w_valid_d = 1'b1;
          w_state_d = StIdle;
        end
      end
      default: w_state_d = StIdle;
    endcase
  end

  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n) begin
      r_state   <= StIdle;
      r_bitcnt  <= '0;
      r_skipcnt <= '0;
      r_shreg   <= '0;
      r_dout    <= '0;
      r_valid   <= 1'b0;
      r_err     <= 1'b0;
    end else begin
      r_state   <= w_state_d;
      r_bitcnt  <= w_bitcnt_d;
      r_skipcnt <= w_skipcnt_d;
      r_shreg   <= w_shreg_d;
      r_dout    <= w_dout_d;
      r_valid   <= w_valid_d;
      r_err     <= w_err_d;
    end
  end

  assign bus.dout  = r_dout;
  assign bus.valid = r_valid;
  assign bus.err   = r_err;
  assign bus.busy  = (r_state != StIdle);
endmodule

// File: doc/spi_receiver.md
SPI_RECEIVER -- requirements
Module: spi_receiver

Interface
REQ-001 Parameter WIDTH, default 12: frame length in bits, which is also the width of dout.
REQ-002 Parameter SKIP_EDGES, default 1: number of sclk falling edges discarded after cs falls and before capture starts.
REQ-003 clk  input  1  system clock; all state updates on its rising edge.
REQ-004 rst_n  input  1  reset, asynchronous and active-low; clears all state immediately when low.
REQ-005 sclk  input  1  serial clock from the upstream SPI transmitter; asynchronous to clk.
REQ-006 cs  input  1  chip select, active-low, asynchronous to clk.
REQ-007 mosi  input  1  serial data, LSB first; changes on rising sclk.
REQ-008 dout  output  WIDTH  last complete received word; holds its value between frames.
REQ-009 valid  output  1  one-clk pulse when dout updates.
REQ-010 err  output  1  one-clk pulse on an aborted frame (cs rises with fewer than WIDTH bits captured).
REQ-011 busy  output  1  high while the FSM is not in IDLE.

Function
REQ-012 sclk, cs and mosi each SHALL pass through a 2-flop synchronizer; the sclk and mosi chains reset to 0, and the cs chain resets to 0.
REQ-013 A falling-sclk event is synced sclk high->low between consecutive clk cycles; the cs-rise and cs-fall events are detected the same way on synced cs.
REQ-014 Input timing: each sclk half-period SHALL be >= 4 clk cycles, and mosi SHALL be stable across each falling sclk edge.
REQ-015 States: IDLE, SKIP, SHIFT, HOLD; reset state IDLE.
- IDLE -> SKIP on a cs-fall event (synced cs was 1, now 0); all other inputs are ignored in IDLE.
- SKIP: count falling-sclk events; after SKIP_EDGES events -> SHIFT with bit counter = 0. If SKIP_EDGES = 0, enter SHIFT directly from IDLE.
- SHIFT: on each falling-sclk event, shift reg[bitcnt] <= synced mosi (LSB first), then bitcnt += 1; when bitcnt reaches WIDTH -> HOLD.
- HOLD: ignore all further sclk edges until cs rises.
REQ-016 A cs-rise event in HOLD SHALL, in the same cycle:
- load dout <= shift register;
- pulse valid for exactly 1 clk;
- go to IDLE.
REQ-017 A cs-rise event in SKIP or SHIFT SHALL pulse err for 1 clk, go to IDLE and leave dout unchanged; valid stays 0.
REQ-018 If a cs-rise event and a falling-sclk event coincide, the cs-rise SHALL take priority and the edge SHALL NOT be captured.
REQ-019 In SHIFT, the edge that captures bit WIDTH-1 SHALL complete the word; a cs-rise in the following cycle SHALL produce valid, not err.
REQ-020 bitcnt width = clog2(WIDTH+1); it SHALL NOT wrap.
REQ-021 Latency: valid SHALL be asserted 3 clk cycles after the raw cs rising edge (2 synchronizer stages + 1 edge-detect/register stage), +0/+1 cycle for sampling phase.
REQ-022 valid and err SHALL never be high in the same cycle.
REQ-023 The shift register SHALL be cleared on entry to SKIP so that bits from an earlier aborted frame never leak into a later word.

Reset
REQ-024 While rst_n = 0: state = IDLE, dout = 0, valid = 0, err = 0, busy = 0, bitcnt = 0, shift register = 0, all synchronizer flops at their REQ-012 values.
REQ-025 Reset asserted mid-frame SHALL abort the frame with no valid and no err pulse.
REQ-026 If cs is already low when rst_n deasserts, this SHALL NOT start a frame (the cs chain resets to 0, so no cs-fall event is seen); the next frame starts only after cs has gone high and then low again.

Verification
REQ-027 Nominal frame: cs low, 1 setup falling edge, then 12 bits of 12'hA5C sent LSB first, then cs high -> dout = 12'hA5C, one valid pulse, err = 0.
REQ-028 Back-to-back frames 12'h001 then 12'hFFF, with cs high for 1 sclk period between them -> two valid pulses; dout = 12'h001 then 12'hFFF.
REQ-029 Abort: cs rises after 7 data bits -> err pulses once, valid = 0, dout keeps its previous value; a following full frame of 12'h3C3 -> dout = 12'h3C3.
REQ-030 Extra edges: 15 data falling edges carrying 12'h123 in the first 12 bits, then cs high -> dout = 12'h123 (edges 13-15 ignored), one valid pulse.
REQ-031 Reset mid-frame: rst_n pulsed low after 5 bits, with cs held low through and after the reset -> no valid and no err, busy = 0; after cs goes high, low, and a full frame of 12'h800 -> dout = 12'h800.
REQ-032 Timing: sclk half-period = 11 clk cycles, matching the upstream transmitter, with random phase between sclk and clk -> all frames received correctly over 1000 random words.
